// File: rtl/state_seq_ctrl.sv
// Prescaled tick sequencer: steps state_idx through NSTATES states, dwelling dwell ticks in each.
// Optional manual single-step in PAUSE is enabled by defining SEQ_STEP_EN.
module state_seq_ctrl #(
    parameter int              CW      = 24,
    parameter logic [CW-1:0]   DIV_MAX = 24'd4999999,
    parameter int              NSTATES = 4,
    parameter int              SW      = 2,
    parameter int              DW      = 8
) (
    input  logic          clkin,
    input  logic          rst_n,
    input  logic          start,
    input  logic          pause,
    input  logic          stop,
    input  logic          step,
    input  logic [DW-1:0] dwell,
    output logic [SW-1:0] state_idx,
    output logic          tick,
    output logic          adv,
    output logic          running
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    localparam logic [SW-1:0] LAST_IDX = SW'(NSTATES - 1);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_remain;
    logic [SW-1:0] r_idx;
    logic          r_tick;
    logic          r_adv;
    logic          r_running;
    logic          w_step_rise;
    logic [DW-1:0] w_dwell_eff;
    logic [SW-1:0] w_idx_next;

    // A zero dwell still holds the state for one tick.
    function automatic logic [DW-1:0] eff_dwell(input logic [DW-1:0] d);
        return (d == {DW{1'b0}}) ? DW'(1) : d;
    endfunction

    assign w_dwell_eff = eff_dwell(dwell);
    assign w_idx_next  = (r_idx == LAST_IDX) ? {SW{1'b0}} : r_idx + SW'(1);

`ifdef SEQ_STEP_EN
    logic r_step_d;

    // Delayed copy of step for rising-edge detection.
    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            r_step_d <= 1'b0;
        end else begin
            r_step_d <= step;
        end
    end

    assign w_step_rise = step & ~r_step_d;
`else
    logic w_unused_step;
    assign w_unused_step = step;
    assign w_step_rise   = 1'b0;
`endif

    // Sequencer FSM with prescaler, dwell counter and registered strobes.
    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= {CW{1'b0}};
            r_remain  <= {DW{1'b0}};
            r_idx     <= {SW{1'b0}};
            r_tick    <= 1'b0;
            r_adv     <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            r_adv  <= 1'b0;
            // dwell now reflects the freshly advanced index
            if (r_adv) begin
                r_remain <= w_dwell_eff;
            end
            if (stop) begin
                r_state   <= S_IDLE;
                r_cnt     <= {CW{1'b0}};
                r_remain  <= {DW{1'b0}};
                r_idx     <= {SW{1'b0}};
                r_running <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_cnt <= {CW{1'b0}};
                        r_idx <= {SW{1'b0}};
                        if (start) begin
                            r_state   <= S_RUN;
                            r_remain  <= w_dwell_eff;
                            r_running <= 1'b1;
                        end else begin
                            r_running <= 1'b0;
                        end
                    end
                    S_RUN: begin
                        if (pause) begin
                            r_state   <= S_PAUSE;
                            r_running <= 1'b0;
                        end else begin
                            r_running <= 1'b1;
                            if (r_cnt == DIV_MAX) begin
                                r_cnt  <= {CW{1'b0}};
                                r_tick <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + CW'(1);
                            end
                            if (r_tick) begin
                                if (r_remain > DW'(1)) begin
                                    r_remain <= r_remain - DW'(1);
                                end else begin
                                    r_idx <= w_idx_next;
                                    r_adv <= 1'b1;
                                end
                            end
                        end
                    end
                    S_PAUSE: begin
                        if (!pause) begin
                            r_state   <= S_RUN;
                            r_running <= 1'b1;
                        end else begin
                            r_running <= 1'b0;
                            if (w_step_rise) begin
                                r_idx <= w_idx_next;
                                r_adv <= 1'b1;
                                r_cnt <= {CW{1'b0}};
                            end
                        end
                    end
                    default: begin
                        r_state   <= S_IDLE;
                        r_running <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign state_idx = r_idx;
    assign tick      = r_tick;
    assign adv       = r_adv;
    assign running   = r_running;

endmodule
